// File: rtl/serial_word_deserializer.sv
// Bit-serial to parallel word receiver for the FIR sample link.
// One output holding register decouples word assembly from a stalled consumer.
module serial_word_deserializer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  output logic                  o_frame_err,
  output logic                  o_overrun
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [CNT_W-1:0]      pos;
  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] sreg_nxt;
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  valid_nxt;
  logic                  ready_nxt;
  logic                  ferr_nxt;
  logic                  ovr_nxt;
  logic                  accept;
  logic                  consume;
  logic                  slot_free;
  logic                  last_bit;

  assign accept    = i_en & i_din_valid & o_ready;
  assign consume   = i_en & o_dout_valid & i_ready;
  assign slot_free = ~o_dout_valid | i_ready;
  assign last_bit  = (cnt == LAST_IDX);
  assign pos       = LSB_FIRST ? cnt : (LAST_IDX - cnt);

  // Shift register with the incoming bit merged, so the last bit can go straight to o_dout.
  always_comb begin
    word_c      = sreg;
    word_c[pos] = i_din;
  end

  // State register plus all datapath/output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      sreg         <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_ready      <= 1'b1;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sreg         <= sreg_nxt;
      o_dout       <= dout_nxt;
      o_dout_valid <= valid_nxt;
      o_ready      <= ready_nxt;
      o_frame_err  <= ferr_nxt;
      o_overrun    <= ovr_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (i_en) begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = SHIFT;
        end
        SHIFT: begin
          if (accept) begin
            if (last_bit) state_nxt = slot_free ? IDLE : FULL;
          end else if (!i_din_valid) begin
            state_nxt = IDLE;
          end
        end
        FULL: begin
          if (consume) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output and datapath next values; i_en low holds everything and silences the pulses.
  always_comb begin
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    dout_nxt  = o_dout;
    valid_nxt = o_dout_valid;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    ready_nxt = (state_nxt != FULL);
    if (i_en) begin
      if (consume) valid_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg_nxt = word_c;
            cnt_nxt  = CNT_W'(1);
          end
        end
        SHIFT: begin
          if (accept) begin
            if (last_bit) begin
              cnt_nxt = '0;
              if (slot_free) begin
                dout_nxt  = word_c;
                valid_nxt = 1'b1;
              end else begin
                sreg_nxt = word_c;
              end
            end else begin
              sreg_nxt = word_c;
              cnt_nxt  = cnt + CNT_W'(1);
            end
          end else if (!i_din_valid) begin
            ferr_nxt = 1'b1;
            cnt_nxt  = '0;
            sreg_nxt = '0;
          end
        end
        FULL: begin
          if (consume) begin
            dout_nxt  = sreg;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
          end
          if (i_din_valid) ovr_nxt = 1'b1;
        end
        default: begin
          cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer: LSB-first and MSB-first instances
// share one serial stream; a negedge monitor checks every handshake against a queue.
module tb_serial_word_deserializer;

  localparam int unsigned W = 24;

  typedef struct {
    logic [W-1:0] lsb;
    logic [W-1:0] msb;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         din;
  logic         din_valid;
  logic         rdy;
  logic         ready_l, ready_m;
  logic [W-1:0] dout_l, dout_m;
  logic         dvalid_l, dvalid_m;
  logic         ferr_l, ferr_m;
  logic         ovr_l, ovr_m;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ferr  = 0;
  int   n_ovr   = 0;

  serial_word_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid),
    .o_ready(ready_l), .o_dout(dout_l), .o_dout_valid(dvalid_l), .i_ready(rdy),
    .o_frame_err(ferr_l), .o_overrun(ovr_l)
  );

  serial_word_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid),
    .o_ready(ready_m), .o_dout(dout_m), .o_dout_valid(dvalid_m), .i_ready(rdy),
    .o_frame_err(ferr_m), .o_overrun(ovr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word on every accepted handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (en && dvalid_l && rdy) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'(dout_l), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_lsb_first", 32'(dout_l), 32'(e.lsb));
          chk("word_msb_first", 32'(dout_m), 32'(e.msb));
          chk("valid_msb_first", 32'(dvalid_m), 32'd1);
        end
      end
      if (ferr_l) n_ferr++;
      if (ovr_l)  n_ovr++;
    end
  end

  // Drive bits lo..hi of w LSB first, one per cycle, inputs changed 1 time unit after the edge.
  task automatic send_range(input logic [W-1:0] w, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      din       = w[k];
      din_valid = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] m);
    exp_t e;
    e.lsb = l;
    e.msb = m;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    rdy       = 1'b1;
    #23;
    rst_n = 1'b1;
    cycles(1);

    chk("reset_dout", 32'(dout_l), 32'd0);
    chk("reset_dout_valid", 32'(dvalid_l), 32'd0);
    chk("reset_ready", 32'(ready_l), 32'd1);
    chk("reset_pulses", {30'd0, ferr_l, ovr_l}, 32'd0);

    // Single word, valid on the last-bit edge for one cycle
    push(24'h5A3C81, 24'h813C5A);
    send_range(24'h5A3C81, 0, W - 1);
    chk("single_valid_rise", 32'(dvalid_l), 32'd1);
    chk("single_dout", 32'(dout_l), 32'h5A3C81);
    chk("single_dout_msb", 32'(dout_m), 32'h813C5A);
    din_valid = 1'b0;
    cycles(1);
    chk("single_valid_one_cycle", 32'(dvalid_l), 32'd0);
    chk("single_no_errors", 32'(n_ferr + n_ovr), 32'd0);

    // Backpressure: two back-to-back words with the consumer stalled
    rdy = 1'b0;
    push(24'h000001, 24'h800000);
    push(24'hFFFFFF, 24'hFFFFFF);
    send_range(24'h000001, 0, W - 1);
    chk("bp_first_held_dout", 32'(dout_l), 32'h000001);
    send_range(24'hFFFFFF, 0, W - 1);
    din_valid = 1'b0;
    chk("bp_first_still_held", 32'(dout_l), 32'h000001);
    chk("bp_full_ready_low", 32'(ready_l), 32'd0);
    cycles(2);
    chk("bp_stable_valid", 32'(dvalid_l), 32'd1);
    rdy = 1'b1;
    cycles(1);
    rdy = 1'b0;
    chk("bp_reload_dout", 32'(dout_l), 32'hFFFFFF);
    chk("bp_reload_valid", 32'(dvalid_l), 32'd1);
    chk("bp_reload_ready", 32'(ready_l), 32'd1);

    // Overrun: fill again, then offer bits while full
    push(24'hC3C3C3, 24'hC3C3C3);
    send_range(24'hC3C3C3, 0, W - 1);
    chk("ovr_full_ready_low", 32'(ready_l), 32'd0);
    din = 1'b1;
    din_valid = 1'b1;
    cycles(3);
    din_valid = 1'b0;
    cycles(2);
    chk("ovr_pulse_count", 32'(n_ovr), 32'd3);
    chk("ovr_word_unchanged", 32'(dout_l), 32'hFFFFFF);
    chk("ovr_still_full", 32'(ready_l), 32'd0);
    rdy = 1'b1;
    cycles(3);
    chk("ovr_drained", 32'(dvalid_l), 32'd0);

    // Frame error after 10 bits, then a clean word
    send_range(24'h0003FF, 0, 9);
    din_valid = 1'b0;
    cycles(2);
    chk("ferr_pulse_count", 32'(n_ferr), 32'd1);
    chk("ferr_no_valid", 32'(dvalid_l), 32'd0);
    chk("ferr_dout_untouched", 32'(dout_l), 32'hC3C3C3);
    push(24'h123456, 24'h6A2C48);
    send_range(24'h123456, 0, W - 1);
    din_valid = 1'b0;
    cycles(2);

    // Enable held low mid-word with garbage on the link
    push(24'hA5F00F, 24'hF00FA5);
    send_range(24'hA5F00F, 0, 7);
    en = 1'b0;
    din = ~din;
    din_valid = 1'b1;
    cycles(5);
    chk("en_low_ready", 32'(ready_l), 32'd1);
    en = 1'b1;
    send_range(24'hA5F00F, 8, W - 1);
    din_valid = 1'b0;
    cycles(2);
    chk("en_no_errors", 32'(n_ferr + n_ovr), 32'd4);

    // Asynchronous reset mid-word with a word pending
    rdy = 1'b0;
    push(24'h5A3C81, 24'h813C5A);
    send_range(24'h5A3C81, 0, W - 1);
    chk("rst_pending_valid", 32'(dvalid_l), 32'd1);
    send_range(24'h123456, 0, 6);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_async_dout", 32'(dout_l), 32'd0);
    chk("rst_async_valid", 32'(dvalid_l), 32'd0);
    chk("rst_async_msb_dout", 32'(dout_m), 32'd0);
    din_valid = 1'b0;
    cycles(1);
    #3;
    rst_n = 1'b1;
    cycles(1);
    chk("rst_release_ready", 32'(ready_l), 32'd1);
    rdy = 1'b1;
    push(24'h123456, 24'h6A2C48);
    send_range(24'h123456, 0, W - 1);
    din_valid = 1'b0;
    cycles(3);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("total_overruns", 32'(n_ovr), 32'd3);
    chk("total_frame_errs", 32'(n_ferr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
